// File: rtl/load_store_buffer.sv
// load_store_buffer: in-order circular queue of loads/stores sitting between the
// instruction unit and the memory controller.
//   clockIn/resetIn/clearIn        : clock, sync active-high reset, mispredict flush
//   add*                            : enqueue port (op, ROB tag, base/offset, store data,
//                                     operand dependency tags); full back-pressures it
//   rsUpdate/rsRobIndex/rsUpdateVal : reservation-station result broadcast (snooped)
//   commitValid/commitRobIndex      : ROB store commit
//   update/updateRobIndex/updateVal : load result broadcast (1-cycle pulse)
//   mem*                            : single-outstanding memory request handshake
// Loads issue speculatively from the head; stores issue only once committed.

// Operand capture for one pending source: picks up a value from the RS broadcast
// (priority) or from this buffer's own load-result bus when the tag matches.
module lsb_snoop #(
  parameter int ROB_WIDTH = 4
) (
  input  logic                 dep,
  input  logic [ROB_WIDTH-1:0] tag,
  input  logic [31:0]          val,
  input  logic                 rs_vld,
  input  logic [ROB_WIDTH-1:0] rs_tag,
  input  logic [31:0]          rs_val,
  input  logic                 up_vld,
  input  logic [ROB_WIDTH-1:0] up_tag,
  input  logic [31:0]          up_val,
  output logic                 dep_n,
  output logic [31:0]          val_n
);
  logic rs_hit, up_hit;
  assign rs_hit = dep && rs_vld && (tag == rs_tag);
  assign up_hit = dep && up_vld && (tag == up_tag);

  always_comb begin
    dep_n = dep;
    val_n = val;
    if (rs_hit) begin
      dep_n = 1'b0;
      val_n = rs_val;
    end else if (up_hit) begin
      dep_n = 1'b0;
      val_n = up_val;
    end
  end
endmodule

module load_store_buffer #(
  parameter int LSB_OP_WIDTH = 4,
  parameter int LSB_WIDTH    = 4,
  parameter int ROB_WIDTH    = 4
) (
  input  logic                    clockIn,
  input  logic                    resetIn,
  input  logic                    clearIn,
  input  logic                    addValid,
  input  logic [LSB_OP_WIDTH-1:0] addOp,
  input  logic [ROB_WIDTH-1:0]    addRobIndex,
  input  logic [31:0]             addBase,
  input  logic                    addHasDepBase,
  input  logic [ROB_WIDTH-1:0]    addConstrtBase,
  input  logic [31:0]             addOffset,
  input  logic [31:0]             addData,
  input  logic                    addHasDepData,
  input  logic [ROB_WIDTH-1:0]    addConstrtData,
  output logic                    full,
  input  logic                    rsUpdate,
  input  logic [ROB_WIDTH-1:0]    rsRobIndex,
  input  logic [31:0]             rsUpdateVal,
  input  logic                    commitValid,
  input  logic [ROB_WIDTH-1:0]    commitRobIndex,
  output logic                    update,
  output logic [ROB_WIDTH-1:0]    updateRobIndex,
  output logic [31:0]             updateVal,
  output logic                    memRequest,
  output logic                    memWrite,
  output logic [31:0]             memAddr,
  output logic [31:0]             memData,
  output logic [1:0]              memSize,
  input  logic                    memDone,
  input  logic [31:0]             memReadData
);
  localparam int DEPTH = 1 << LSB_WIDTH;

  typedef struct packed {
    logic                    valid;
    logic [LSB_OP_WIDTH-1:0] op;
    logic [ROB_WIDTH-1:0]    rob;
    logic [31:0]             base;
    logic                    base_dep;
    logic [ROB_WIDTH-1:0]    base_tag;
    logic [31:0]             offset;
    logic [31:0]             data;
    logic                    data_dep;
    logic [ROB_WIDTH-1:0]    data_tag;
    logic                    committed;
  } entry_t;

  typedef enum logic {IDLE, WAIT_MEM} state_t;

  entry_t               ent [DEPTH];
  entry_t               hd, add_ent;
  logic [LSB_WIDTH-1:0] head, tail, idx;
  logic [LSB_WIDTH:0]   count, kept;
  state_t               state, state_n;
  logic                 squash, head_ready, issue, pop, enq, run;

  logic [DEPTH-1:0]       base_dep_n, data_dep_n, commit_hit, drop;
  logic [DEPTH-1:0][31:0] base_val_n, data_val_n;
  logic                   add_base_dep, add_data_dep;
  logic [31:0]            add_base_val, add_data_val;

  function automatic logic [31:0] store_mask(input logic [31:0] d, input logic [1:0] sz);
    case (sz)
      2'b00:   return {24'h0, d[7:0]};
      2'b01:   return {16'h0, d[15:0]};
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(input logic [31:0] d, input logic uns,
                                           input logic [1:0] sz);
    case (sz)
      2'b00:   return uns ? {24'h0, d[7:0]}  : {{24{d[7]}}, d[7:0]};
      2'b01:   return uns ? {16'h0, d[15:0]} : {{16{d[15]}}, d[15:0]};
      default: return d;
    endcase
  endfunction

  assign full = (count == (LSB_WIDTH+1)'(DEPTH));
  assign enq  = addValid && !full && !clearIn;
  assign hd   = ent[head];

  assign head_ready = hd.valid && !hd.base_dep &&
                      (!hd.op[3] || (!hd.data_dep && hd.committed));

  // Per-entry operand snooping, commit match and flush-drop decision.
  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    lsb_snoop #(.ROB_WIDTH(ROB_WIDTH)) u_base (
      .dep(ent[g].valid && ent[g].base_dep), .tag(ent[g].base_tag), .val(ent[g].base),
      .rs_vld(rsUpdate), .rs_tag(rsRobIndex), .rs_val(rsUpdateVal),
      .up_vld(update), .up_tag(updateRobIndex), .up_val(updateVal),
      .dep_n(base_dep_n[g]), .val_n(base_val_n[g]));
    lsb_snoop #(.ROB_WIDTH(ROB_WIDTH)) u_data (
      .dep(ent[g].valid && ent[g].data_dep), .tag(ent[g].data_tag), .val(ent[g].data),
      .rs_vld(rsUpdate), .rs_tag(rsRobIndex), .rs_val(rsUpdateVal),
      .up_vld(update), .up_tag(updateRobIndex), .up_val(updateVal),
      .dep_n(data_dep_n[g]), .val_n(data_val_n[g]));
    assign commit_hit[g] = commitValid && ent[g].valid && ent[g].op[3] &&
                           (ent[g].rob == commitRobIndex);
    // Distance from head decides whether a flush keeps this slot.
    assign drop[g] = ({1'b0, LSB_WIDTH'(g) - head} >= kept);
  end

  // Enqueue-time forwarding uses the same capture logic as resident entries.
  lsb_snoop #(.ROB_WIDTH(ROB_WIDTH)) u_add_base (
    .dep(addHasDepBase), .tag(addConstrtBase), .val(addBase),
    .rs_vld(rsUpdate), .rs_tag(rsRobIndex), .rs_val(rsUpdateVal),
    .up_vld(update), .up_tag(updateRobIndex), .up_val(updateVal),
    .dep_n(add_base_dep), .val_n(add_base_val));
  lsb_snoop #(.ROB_WIDTH(ROB_WIDTH)) u_add_data (
    .dep(addHasDepData), .tag(addConstrtData), .val(addData),
    .rs_vld(rsUpdate), .rs_tag(rsRobIndex), .rs_val(rsUpdateVal),
    .up_vld(update), .up_tag(updateRobIndex), .up_val(updateVal),
    .dep_n(add_data_dep), .val_n(add_data_val));

  always_comb begin
    add_ent           = '0;
    add_ent.valid     = 1'b1;
    add_ent.op        = addOp;
    add_ent.rob       = addRobIndex;
    add_ent.base      = add_base_val;
    add_ent.base_dep  = add_base_dep;
    add_ent.base_tag  = addConstrtBase;
    add_ent.offset    = addOffset;
    add_ent.data      = add_data_val;
    add_ent.data_dep  = add_data_dep;
    add_ent.data_tag  = addConstrtData;
    add_ent.committed = 1'b0;
  end

  // Flush survivors: the in-flight head (its slot must stay until memDone pops
  // it) followed by the contiguous run of committed stores, counting commits
  // arriving this very cycle.
  always_comb begin
    kept = '0;
    run  = 1'b1;
    idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + LSB_WIDTH'(i);
      if (run && ((LSB_WIDTH+1)'(i) < count) && ent[idx].valid &&
          ((i == 0 && state == WAIT_MEM) ||
           (ent[idx].op[3] && (ent[idx].committed || commit_hit[idx]))))
        kept = kept + 1'b1;
      else
        run = 1'b0;
    end
  end

  always_ff @(posedge clockIn) begin
    if (resetIn) state <= IDLE;
    else         state <= state_n;
  end

  // Issue is held off during a flush cycle so the head being discarded never
  // leaves for memory.
  always_comb begin
    state_n = state;
    issue   = 1'b0;
    pop     = 1'b0;
    case (state)
      IDLE: if (head_ready && !clearIn) begin
        issue   = 1'b1;
        state_n = WAIT_MEM;
      end
      WAIT_MEM: if (memDone) begin
        pop     = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clockIn) begin
    if (resetIn) begin
      head           <= '0;
      tail           <= '0;
      count          <= '0;
      squash         <= 1'b0;
      update         <= 1'b0;
      updateRobIndex <= '0;
      updateVal      <= '0;
      memRequest     <= 1'b0;
      memWrite       <= 1'b0;
      memAddr        <= '0;
      memData        <= '0;
      memSize        <= '0;
      for (int i = 0; i < DEPTH; i++) ent[i].valid <= 1'b0;
    end else begin
      update <= 1'b0;

      for (int i = 0; i < DEPTH; i++) begin
        if (ent[i].valid) begin
          ent[i].base_dep <= base_dep_n[i];
          ent[i].base     <= base_val_n[i];
          ent[i].data_dep <= data_dep_n[i];
          ent[i].data     <= data_val_n[i];
          if (commit_hit[i]) ent[i].committed <= 1'b1;
        end
      end

      if (issue) begin
        memRequest <= 1'b1;
        memWrite   <= hd.op[3];
        memAddr    <= hd.base + hd.offset;
        memSize    <= hd.op[1:0];
        memData    <= store_mask(hd.data, hd.op[1:0]);
      end

      if (pop) begin
        memRequest      <= 1'b0;
        ent[head].valid <= 1'b0;
        // A flush landing on the completion cycle squashes the load as well.
        if (!hd.op[3] && !squash && !clearIn) begin
          update         <= 1'b1;
          updateRobIndex <= hd.rob;
          updateVal      <= load_ext(memReadData, hd.op[2], hd.op[1:0]);
        end
        squash <= 1'b0;
      end

      if (clearIn) begin
        for (int i = 0; i < DEPTH; i++)
          if (drop[i]) ent[i].valid <= 1'b0;
        if (state == WAIT_MEM && !hd.op[3] && !pop) squash <= 1'b1;
        tail  <= head + kept[LSB_WIDTH-1:0];
        head  <= head + LSB_WIDTH'(pop);
        count <= kept - (LSB_WIDTH+1)'(pop);
      end else begin
        if (enq) begin
          ent[tail] <= add_ent;
          tail      <= tail + 1'b1;
        end
        head  <= head + LSB_WIDTH'(pop);
        count <= count + (LSB_WIDTH+1)'(enq) - (LSB_WIDTH+1)'(pop);
      end
    end
  end
endmodule
